// File: rtl/rc5_dec_16bit.sv
// 16-bit RC5 block decipher (w=8), one half-round per cycle.
// The S-table is latched on start so upstream may change key/c afterwards.
module rc5_dec_16bit #(
  parameter int ROUNDS = 2,
  parameter int KW     = 16*(ROUNDS+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dec_start,
  input  logic [15:0]   c,
  input  logic [KW-1:0] key,
  output logic [15:0]   p,
  output logic          dec_done,
  output logic          busy
);

  // state | meaning
  // IDLE  | waiting for dec_start, busy low
  // RB    | undo B half of round rnd
  // RA    | undo A half of round rnd, then next round or whitening
  // WH    | remove input whitening, publish p, pulse dec_done

  localparam int NS = 2*ROUNDS+2;
  localparam int IW = $clog2(NS);

  typedef enum logic [1:0] {IDLE, RB, RA, WH} state_t;

  state_t             state, state_n;
  logic [2:0]         rnd, rnd_n;
  logic [7:0]         a, a_n, b, b_n;
  logic [NS-1:0][7:0] s_tab, s_tab_n;
  logic [15:0]        p_n;
  logic               dec_done_n, busy_n;
  logic [IW-1:0]      idx_a, idx_b;

  assign idx_a = IW'({rnd, 1'b0});
  assign idx_b = IW'({rnd, 1'b1});

  function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} >> n;
    return t[7:0];
  endfunction

  always_comb begin
    state_n    = state;
    rnd_n      = rnd;
    a_n        = a;
    b_n        = b;
    s_tab_n    = s_tab;
    p_n        = p;
    dec_done_n = 1'b0;
    busy_n     = busy;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (dec_start) begin
          a_n     = c[15:8];
          b_n     = c[7:0];
          s_tab_n = key;
          rnd_n   = 3'(ROUNDS);
          busy_n  = 1'b1;
          state_n = RB;
        end
      end
      RB: begin
        b_n     = rotr(b - s_tab[idx_b], a[2:0]) ^ a;
        state_n = RA;
      end
      RA: begin
        a_n = rotr(a - s_tab[idx_a], b[2:0]) ^ b;
        if (rnd == 3'd1) begin
          state_n = WH;
        end else begin
          rnd_n   = rnd - 3'd1;
          state_n = RB;
        end
      end
      WH: begin
        p_n        = {a - s_tab[0], b - s_tab[1]};
        dec_done_n = 1'b1;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rnd      <= 3'd0;
      a        <= 8'h00;
      b        <= 8'h00;
      s_tab    <= '0;
      p        <= 16'h0000;
      dec_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      rnd      <= rnd_n;
      a        <= a_n;
      b        <= b_n;
      s_tab    <= s_tab_n;
      p        <= p_n;
      dec_done <= dec_done_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_rc5_dec_16bit.sv
// Bench for rc5_dec_16bit: directed vectors on ROUNDS=2 plus
// encrypt/decrypt round trips on ROUNDS=2, 1 and 7.
module tb_rc5_dec_16bit;

  logic         clock;
  logic         reset;
  logic         st_v   [3];
  logic [15:0]  c_v    [3];
  logic [15:0]  p_v    [3];
  logic         done_v [3];
  logic         busy_v [3];
  logic [47:0]  key0;
  logic [31:0]  key1;
  logic [127:0] key2;

  int checks   = 0;
  int failures = 0;

  rc5_dec_16bit #(.ROUNDS(2)) u_dec0 (
    .clock(clock), .reset(reset), .dec_start(st_v[0]), .c(c_v[0]), .key(key0),
    .p(p_v[0]), .dec_done(done_v[0]), .busy(busy_v[0]));
  rc5_dec_16bit #(.ROUNDS(1)) u_dec1 (
    .clock(clock), .reset(reset), .dec_start(st_v[1]), .c(c_v[1]), .key(key1),
    .p(p_v[1]), .dec_done(done_v[1]), .busy(busy_v[1]));
  rc5_dec_16bit #(.ROUNDS(7)) u_dec2 (
    .clock(clock), .reset(reset), .dec_start(st_v[2]), .c(c_v[2]), .key(key2),
    .p(p_v[2]), .dec_done(done_v[2]), .busy(busy_v[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] c;
    logic [47:0] key;
    logic [15:0] exp_p;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Reference encryptor: the operation the decipher must invert.
  function automatic logic [15:0] enc(input logic [127:0] k, input int r, input logic [15:0] pt);
    logic [7:0] ea, eb;
    ea = pt[15:8] + k[7:0];
    eb = pt[7:0] + k[15:8];
    for (int i = 1; i <= r; i++) begin
      ea = rotl(ea ^ eb, eb[2:0]) + k[16*i +: 8];
      eb = rotl(eb ^ ea, ea[2:0]) + k[16*i+8 +: 8];
    end
    return {ea, eb};
  endfunction

  task automatic drive(input int sel, input logic s, input logic [15:0] cv, input logic [127:0] k);
    st_v[sel] = s;
    c_v[sel]  = cv;
    case (sel)
      0:       key0 = k[47:0];
      1:       key1 = k[31:0];
      default: key2 = k;
    endcase
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    drive(0, 1'b1, v.c, {80'h0, v.key});
    @(negedge clock);
    drive(0, 1'b0, 16'hFFFF, 128'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      check("busy_during_op", busy_v[0], 1);
      check("no_early_done", done_v[0], 0);
      if (k == 4) check("internal_b_pre_whiten", u_dec0.b, v.exp_b);
    end
    @(negedge clock);
    check("done_pulse", done_v[0], 1);
    check("busy_after_done", busy_v[0], 0);
    check("plaintext", p_v[0], v.exp_p);
    @(negedge clock);
    check("done_cleared", done_v[0], 0);
    check("plaintext_held", p_v[0], v.exp_p);
  endtask

  task automatic run_rt(input int sel, input int rounds);
    logic [15:0]  pt;
    logic [127:0] k;
    int           cnt;
    @(negedge clock);
    for (int n = 0; n < 200; n++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt = 16'($urandom());
      drive(sel, 1'b1, enc(k, rounds, pt), k);
      cnt = 0;
      do begin
        @(negedge clock);
        cnt++;
      end while (!done_v[sel] && cnt < 40);
      check("rt_done_seen", done_v[sel], 1);
      check("rt_plaintext", p_v[sel], pt);
      check("rt_interval", cnt, 2*rounds+2);
    end
    drive(sel, 1'b0, 16'h0, 128'h0);
    repeat (2*rounds+4) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    vecs[0] = '{c: 16'hBF40, key: 48'h665544332211, exp_p: 16'h1234, exp_b: 8'h56};
    vecs[1] = '{c: 16'h0102, key: 48'h000000000000, exp_p: 16'h8101, exp_b: 8'h01};
    vecs[2] = '{c: 16'h0000, key: 48'hFFFFFFFFFFFF, exp_p: 16'h0381, exp_b: 8'h80};

    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 16'h0, 128'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("idle_p", p_v[0], 16'h0000);
      check("idle_done", done_v[0], 0);
      check("idle_busy", busy_v[0], 0);
    end

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Start while busy: second request at T+2 must be dropped.
    @(negedge clock);
    drive(0, 1'b1, 16'hBF40, {80'h0, 48'h665544332211});
    @(negedge clock);
    drive(0, 1'b0, 16'hBF40, {80'h0, 48'h665544332211});
    @(negedge clock);
    drive(0, 1'b1, 16'h0000, {80'h0, 48'h665544332211});
    @(negedge clock);
    drive(0, 1'b0, 16'h0000, {80'h0, 48'h665544332211});
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done_v[0]) n_done++;
    end
    check("busy_start_done_count", n_done, 1);
    check("busy_start_result", p_v[0], 16'h1234);
    check("busy_start_idle", busy_v[0], 0);

    // Reset between T+2 and T+3 abandons the operation.
    @(negedge clock);
    drive(0, 1'b1, 16'hBF40, {80'h0, 48'h665544332211});
    @(negedge clock);
    drive(0, 1'b0, 16'h0000, 128'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset_p", p_v[0], 16'h0000);
    check("midreset_busy", busy_v[0], 0);
    check("midreset_done", done_v[0], 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (done_v[0]) n_done++;
    end
    check("midreset_no_done", n_done, 0);
    check("midreset_p_held", p_v[0], 16'h0000);
    run_vec(vecs[0]);

    run_rt(0, 2);
    run_rt(1, 1);
    run_rt(2, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc5_dec_16bit.md
Name: rc5_dec_16bit

Overview:
- 16-bit RC5 block decipher, w=8, r=ROUNDS, with a 2*ROUNDS+2 byte key table.
- Inverse of the team's 16-bit RC5 encryptor: ciphertext in, plaintext out, using the same S-table the encryptor used.
- Key table is supplied as a flat input bus and latched on start. The block never generates keys itself.
- Sits on the receive side of the link, behind the ciphertext capture register.

Parameters:
- ROUNDS, 2, number of RC5 rounds. Legal range 1..7.
- KW, 16*(ROUNDS+1), key bus width (derived; do not override).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- dec_start  input  1  request. Sampled only in IDLE.
- c  input  16  ciphertext. c[15:8] = A half, c[7:0] = B half.
- key  input  KW  S-table. S[k] = key[8k+7:8k], k = 0..2*ROUNDS+1.
- p  output  16  plaintext result register. Holds the value until the next completion.
- dec_done  output  1  one-cycle pulse when p updates.
- busy  output  1  high from start acceptance until completion.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, p=16'h0000, dec_done=0, busy=0.
  - Internal a/b/key copy and round counter cleared.
  - Reset mid-operation abandons the decryption; no done pulse.
- All arithmetic is 8-bit modulo 256. rotr(x,n) is a right rotate of 8 bits by n=0..7; rotate by 0 returns x.
- Rotate amount is always the low 3 bits of the other half's current value.
- IDLE:
  - busy=0.
  - If dec_start=1 at edge T: a<=c[15:8], b<=c[7:0], key copy<=key, rnd<=ROUNDS, busy<=1, state<=RB.
  - c and key may change after T without effect.
- RB: b <= rotr(b - S[2*rnd+1], a[2:0]) ^ a; state<=RA.
- RA:
  - a <= rotr(a - S[2*rnd], b[2:0]) ^ b.
  - If rnd==1: state<=WH. Else rnd<=rnd-1, state<=RB.
- WH:
  - p <= {a - S[0], b - S[1]}, dec_done<=1, busy<=0, state<=IDLE.
  - dec_done clears on the following edge.
- Latency: start accepted at edge T → p valid and dec_done high after edge T+2*ROUNDS+1 (T+5 at default).
  - Next start is accepted no earlier than edge T+2*ROUNDS+2.
  - dec_start held high gives back-to-back decryptions, one every 2*ROUNDS+2 cycles.
- dec_start while busy=1 is ignored, not queued.
- dec_start coincident with the WH edge is ignored; it is accepted on the next edge if still high.
- Only state, rnd, a, b, key copy, p, dec_done and busy are registered. p is never driven combinationally.
- Round-trip property: for any key K and plaintext P, decrypting RC5_enc(K,P) returns P.

Test Plan:
- Reset then idle: reset low for 3 cycles, release, dec_start=0 → p=0x0000, dec_done=0, busy=0 indefinitely.
- Known vector: key=48'h665544332211, c=0xBF40, dec_start pulse at edge T → busy=1 for edges T..T+4; dec_done pulse after T+5; p=0x1234.
- Rotate-by-zero and wrap paths: the same vector exercises a rotate of 0 (a=0x90) and a subtract wrap (0x0A-0x44=0xC6). Check the internal b value 0x56 before the final whitening step.
- Start while busy: second dec_start with c=0x0000 at T+2 → ignored; result still 0x1234, exactly one dec_done pulse.
- Reset mid-operation: assert reset at T+3 → p=0x0000, busy=0, no dec_done. A subsequent start with c=0xBF40 yields 0x1234.
- Back-to-back and round-trip: dec_start held high, 200 random keys/plaintexts encrypted by the reference model → every p equals the original plaintext, dec_done every 6 cycles. Repeat with ROUNDS=1 and ROUNDS=7.
